// File: rtl/im_frame_sync_ctrl_pkg.sv
// Shared types and constants for the frame-synchronous image-memory location scheduler.
package im_ctrl_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned Y_LSB   = 16;
  localparam int unsigned X_LSB   = 0;
  localparam int unsigned NUM_OBJ = 3;
  localparam int unsigned OBJ_W   = 2;
  localparam int unsigned DATA_W  = 32;

  localparam logic [OBJ_W-1:0] OBJ_BALL = 2'd0;
  localparam logic [OBJ_W-1:0] OBJ_BARL = 2'd1;
  localparam logic [OBJ_W-1:0] OBJ_BARR = 2'd2;
  localparam logic [OBJ_W-1:0] OBJ_INV  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Location register word as seen by the image memory: {6'b0, y, 6'b0, x}
  typedef struct packed {
    logic [5:0]         rsv_y;
    logic [COORD_W-1:0] y;
    logic [5:0]         rsv_x;
    logic [COORD_W-1:0] x;
  } loc_word_t;

  // Saturate a coordinate to lim-1
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input int unsigned lim);
    if (32'(v) >= lim) return COORD_W'(lim - 1);
    return v;
  endfunction

endpackage

// File: rtl/im_frame_sync_ctrl_if.sv
// CPU request handshake and image-memory location write port.
//   req_valid/req_obj/req_data/req_ready : location write request (valid&ready accepts)
//   loc_en/loc_sel/loc_wdata             : one-cycle location register write strobe
interface im_frame_sync_ctrl_if;
  import im_ctrl_pkg::*;

  logic                 req_valid;
  logic [OBJ_W-1:0]     req_obj;
  logic [DATA_W-1:0]    req_data;
  logic                 req_ready;
  logic                 loc_en;
  logic [OBJ_W-1:0]     loc_sel;
  logic [DATA_W-1:0]    loc_wdata;

  modport master (
    output req_valid, req_obj, req_data,
    input  req_ready, loc_en, loc_sel, loc_wdata
  );

  modport slave (
    input  req_valid, req_obj, req_data,
    output req_ready, loc_en, loc_sel, loc_wdata
  );

endinterface

// File: rtl/im_vblank_det.sv
// Vertical-blank detector: registers (pixel_y >= V_ACTIVE) and flags its rising edge.
//   clk, rst        : clock, async active-low reset
//   pixel_y_i       : current scan line
//   frame_start_c   : combinational one-cycle pulse on vblank entry
module im_vblank_det
  import im_ctrl_pkg::*;
#(
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pixel_y_i,
  output logic               frame_start_c
);

  logic vblank_c;
  logic vblank_q;

  assign vblank_c = (32'(pixel_y_i) >= V_ACTIVE);

  // Resets to 1 so releasing reset inside vblank does not look like a vblank entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vblank_q <= 1'b1;
    else      vblank_q <= vblank_c;
  end

  assign frame_start_c = vblank_c & ~vblank_q;

endmodule

// File: rtl/im_frame_sync_ctrl.sv
// Frame-synchronous update scheduler for the ball / left bar / right bar location registers.
// CPU writes land in per-object shadow slots; on vblank entry pending slots are written to
// the image memory in a fixed 3-cycle sequence followed by a one-cycle frame_irq.
//   clk, rst            : clock, async active-low reset
//   pixel_x, pixel_y    : scan position (pixel_x reserved)
//   bus (slave)         : request handshake and location write port
//   freeze, ovr_clr     : commit suppression level, overwrite flag clear
//   pending, ovr        : per-object pending flags, sticky overwrite flag
//   frame_cnt, frame_irq: vblank entry counter, end-of-commit pulse
module im_frame_sync_ctrl
  import im_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned FCNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COORD_W-1:0]   pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  im_frame_sync_ctrl_if.slave  bus,
  input  logic                 freeze,
  input  logic                 ovr_clr,
  output logic [NUM_OBJ-1:0]   pending,
  output logic                 ovr,
  output logic [FCNT_W-1:0]    frame_cnt,
  output logic                 frame_irq
);

  logic                frame_start_c;
  state_e              state_q;
  logic [OBJ_W-1:0]    idx_q;
  logic [OBJ_W-1:0]    nidx_c;
  loc_word_t           shadow_q [NUM_OBJ];
  loc_word_t           shadow_c [NUM_OBJ];
  loc_word_t           req_word_c;
  logic [NUM_OBJ-1:0]  pend_q;
  logic [NUM_OBJ-1:0]  pend_acc_c;
  logic                acc_c;
  logic                ovr_set_c;
  logic                rdy_q;
  logic                loc_en_q;
  logic [OBJ_W-1:0]    loc_sel_q;
  loc_word_t           loc_wdata_q;
  logic                ovr_q;
  logic [FCNT_W-1:0]   cnt_q;
  logic                irq_q;
  logic                unused_bits;

  im_vblank_det #(.V_ACTIVE(V_ACTIVE)) u_vblank_det (
    .clk           (clk),
    .rst           (rst),
    .pixel_y_i     (pixel_y),
    .frame_start_c (frame_start_c)
  );

  // Accept path: clamp the request and fold it into the shadow/pending view, so a request
  // accepted alongside frame_start is part of that commit
  always_comb begin
    req_word_c   = '0;
    req_word_c.x = clamp_coord(bus.req_data[X_LSB +: COORD_W], H_ACTIVE);
    req_word_c.y = clamp_coord(bus.req_data[Y_LSB +: COORD_W], V_ACTIVE);
    acc_c        = bus.req_valid & rdy_q & (bus.req_obj != OBJ_INV);
    pend_acc_c   = pend_q;
    shadow_c     = shadow_q;
    ovr_set_c    = 1'b0;
    nidx_c       = idx_q + 2'd1;
    if (acc_c) begin
      pend_acc_c[bus.req_obj] = 1'b1;
      shadow_c[bus.req_obj]   = req_word_c;
      ovr_set_c               = pend_q[bus.req_obj];
    end
  end

  // Scheduler FSM; strobes are registered one cycle ahead so idx_q names the slot on the bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pend_q      <= '0;
      shadow_q    <= '{default: '0};
      rdy_q       <= 1'b0;
      loc_en_q    <= 1'b0;
      loc_sel_q   <= '0;
      loc_wdata_q <= '0;
      ovr_q       <= 1'b0;
      cnt_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      loc_en_q <= 1'b0;
      irq_q    <= 1'b0;
      shadow_q <= shadow_c;
      ovr_q    <= ovr_set_c | (ovr_q & ~ovr_clr);
      if (frame_start_c) cnt_q <= cnt_q + FCNT_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          pend_q <= pend_acc_c;
          rdy_q  <= 1'b1;
          if (frame_start_c) begin
            rdy_q <= 1'b0;
            if (!freeze && (|pend_acc_c)) begin
              state_q          <= ST_COMMIT;
              idx_q            <= OBJ_BALL;
              pend_q[OBJ_BALL] <= 1'b0;
              if (pend_acc_c[OBJ_BALL]) begin
                loc_en_q    <= 1'b1;
                loc_sel_q   <= OBJ_BALL;
                loc_wdata_q <= shadow_c[OBJ_BALL];
              end
            end else begin
              state_q <= ST_DONE;
              irq_q   <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          if (idx_q == OBJ_BARR) begin
            state_q <= ST_DONE;
            irq_q   <= 1'b1;
          end else begin
            idx_q          <= nidx_c;
            pend_q[nidx_c] <= 1'b0;
            if (pend_q[nidx_c]) begin
              loc_en_q    <= 1'b1;
              loc_sel_q   <= nidx_c;
              loc_wdata_q <= shadow_q[nidx_c];
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.loc_en    = loc_en_q;
  assign bus.loc_sel   = loc_sel_q;
  assign bus.loc_wdata = loc_wdata_q;
  assign pending       = pend_q;
  assign ovr           = ovr_q;
  assign frame_cnt     = cnt_q;
  assign frame_irq     = irq_q;

  // Reserved / ignored inputs
  assign unused_bits = ^{pixel_x, bus.req_data[DATA_W-1:Y_LSB+COORD_W],
                         bus.req_data[Y_LSB-1:X_LSB+COORD_W]};

endmodule

// File: tb/tb_im_frame_sync_ctrl.sv
// Directed bench for im_frame_sync_ctrl: commit timing, overwrite, clamp, freeze, reset.
module tb_im_frame_sync_ctrl;
  import im_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic [COORD_W-1:0]  pixel_x;
  logic [COORD_W-1:0]  pixel_y;
  logic                freeze;
  logic                ovr_clr;
  logic [NUM_OBJ-1:0]  pending;
  logic                ovr;
  logic [15:0]         frame_cnt;
  logic                frame_irq;

  im_frame_sync_ctrl_if bus();

  im_frame_sync_ctrl #(.H_ACTIVE(640), .V_ACTIVE(480), .FCNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .bus       (bus),
    .freeze    (freeze),
    .ovr_clr   (ovr_clr),
    .pending   (pending),
    .ovr       (ovr),
    .frame_cnt (frame_cnt),
    .frame_irq (frame_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int strb_cnt = 0;
  int irq_cnt  = 0;
  int s0, i0;

  logic [31:0] c_en  [1:6];
  logic [31:0] c_sel [1:6];
  logic [31:0] c_wd  [1:6];
  logic [31:0] c_irq [1:6];
  logic [31:0] c_rdy [1:6];

  // Outputs change on posedge; counting there sees the value of the cycle just ended
  always @(posedge clk) begin
    if (bus.loc_en === 1'b1) strb_cnt++;
    if (frame_irq === 1'b1)  irq_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] obj, input logic [31:0] data, input logic clr);
    bus.req_valid = 1'b1;
    bus.req_obj   = obj;
    bus.req_data  = data;
    ovr_clr       = clr;
    @(negedge clk);
    bus.req_valid = 1'b0;
    ovr_clr       = 1'b0;
  endtask

  task automatic go_active();
    pixel_y = 10'd100;
    @(negedge clk);
  endtask

  // 479 -> 480 transition; index k holds what is visible during cycle T+k
  task automatic vbl_enter();
    pixel_y = 10'd479;
    @(negedge clk);
    pixel_y = 10'd480;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      c_en[k]  = 32'(bus.loc_en);
      c_sel[k] = 32'(bus.loc_sel);
      c_wd[k]  = bus.loc_wdata;
      c_irq[k] = 32'(frame_irq);
      c_rdy[k] = 32'(bus.req_ready);
    end
  endtask

  initial begin
    rst = 1'b0; pixel_x = '0; pixel_y = 10'd500; freeze = 1'b0; ovr_clr = 1'b0;
    bus.req_valid = 1'b0; bus.req_obj = '0; bus.req_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_loc_en", 32'(bus.loc_en), 32'd0);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_wdata", bus.loc_wdata, 32'd0);

    // Release inside vblank: no frame_start
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rel_irq_cnt", 32'(irq_cnt), 32'd0);
    check_eq("rel_frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("rel_ready", 32'(bus.req_ready), 32'd1);

    // Single ball update
    go_active();
    wr(OBJ_BALL, 32'h0064_0032, 1'b0);
    check_eq("t1_pend_before", 32'(pending), 32'b001);
    s0 = strb_cnt;
    vbl_enter();
    check_eq("t1_en1", c_en[1], 32'd1);
    check_eq("t1_sel1", c_sel[1], 32'd0);
    check_eq("t1_wd1", c_wd[1], 32'h0064_0032);
    check_eq("t1_en2", c_en[2], 32'd0);
    check_eq("t1_wd2_hold", c_wd[2], 32'h0064_0032);
    check_eq("t1_irq3", c_irq[3], 32'd0);
    check_eq("t1_irq4", c_irq[4], 32'd1);
    check_eq("t1_rdy4", c_rdy[4], 32'd0);
    check_eq("t1_rdy5", c_rdy[5], 32'd1);
    check_eq("t1_strobes", 32'(strb_cnt - s0), 32'd1);
    check_eq("t1_pend_after", 32'(pending), 32'd0);
    check_eq("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Left bar written twice before vblank: last wins, ovr set
    go_active();
    wr(OBJ_BARL, 32'h0010_0010, 1'b0);
    check_eq("t2_ovr0", 32'(ovr), 32'd0);
    wr(OBJ_BARL, 32'h0020_0020, 1'b0);
    check_eq("t2_ovr1", 32'(ovr), 32'd1);
    check_eq("t2_pend", 32'(pending), 32'b010);
    s0 = strb_cnt;
    vbl_enter();
    check_eq("t2_en1", c_en[1], 32'd0);
    check_eq("t2_en2", c_en[2], 32'd1);
    check_eq("t2_sel2", c_sel[2], 32'd1);
    check_eq("t2_wd2", c_wd[2], 32'h0020_0020);
    check_eq("t2_strobes", 32'(strb_cnt - s0), 32'd1);
    check_eq("t2_irq4", c_irq[4], 32'd1);

    // ovr clear, then clear colliding with a new overwrite (set wins)
    go_active();
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check_eq("t2_ovr_clr", 32'(ovr), 32'd0);
    wr(OBJ_BARL, 32'h0005_0005, 1'b0);
    check_eq("t2_ovr_first", 32'(ovr), 32'd0);
    wr(OBJ_BARL, 32'h0006_0006, 1'b1);
    check_eq("t2_ovr_setwins", 32'(ovr), 32'd1);

    // Right bar out of range plus an invalid object write
    wr(OBJ_BARR, 32'h0384_03E8, 1'b0);
    wr(OBJ_INV, 32'h0001_0001, 1'b0);
    check_eq("t3_pend", 32'(pending), 32'b110);
    s0 = strb_cnt;
    vbl_enter();
    check_eq("t3_en1", c_en[1], 32'd0);
    check_eq("t3_wd2", c_wd[2], 32'h0006_0006);
    check_eq("t3_en3", c_en[3], 32'd1);
    check_eq("t3_sel3", c_sel[3], 32'd2);
    check_eq("t3_wd3_clamp", c_wd[3], 32'h01DF_027F);
    check_eq("t3_strobes", 32'(strb_cnt - s0), 32'd2);
    check_eq("t3_frame_cnt", 32'(frame_cnt), 32'd3);

    // Freeze across two vblanks, then release
    freeze = 1'b1;
    go_active();
    wr(OBJ_BALL, 32'h0001_0002, 1'b0);
    s0 = strb_cnt;
    vbl_enter();
    check_eq("t4_irq1", c_irq[1], 32'd1);
    check_eq("t4_irq2", c_irq[2], 32'd0);
    check_eq("t4_rdy2", c_rdy[2], 32'd1);
    go_active();
    vbl_enter();
    check_eq("t4b_irq1", c_irq[1], 32'd1);
    check_eq("t4_strobes", 32'(strb_cnt - s0), 32'd0);
    check_eq("t4_pend_kept", 32'(pending), 32'b001);
    check_eq("t4_frame_cnt", 32'(frame_cnt), 32'd5);
    freeze = 1'b0;
    go_active();
    vbl_enter();
    check_eq("t4c_en1", c_en[1], 32'd1);
    check_eq("t4c_wd1", c_wd[1], 32'h0001_0002);
    check_eq("t4c_irq4", c_irq[4], 32'd1);
    check_eq("t4c_pend", 32'(pending), 32'd0);

    // Request raised during COMMIT waits until T+5 and pends for the next frame
    go_active();
    wr(OBJ_BARR, 32'h0003_0004, 1'b0);
    pixel_y = 10'd479;
    @(negedge clk);
    pixel_y = 10'd480;
    @(negedge clk);
    check_eq("t5_rdy1", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b1; bus.req_obj = OBJ_BALL; bus.req_data = 32'h0007_0008;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      c_en[k]  = 32'(bus.loc_en);
      c_wd[k]  = bus.loc_wdata;
      c_rdy[k] = 32'(bus.req_ready);
      if (k == 4) check_eq("t5_pend_t4", 32'(pending), 32'd0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("t5_en3", c_en[3], 32'd1);
    check_eq("t5_wd3", c_wd[3], 32'h0003_0004);
    check_eq("t5_rdy4", c_rdy[4], 32'd0);
    check_eq("t5_rdy5", c_rdy[5], 32'd1);
    check_eq("t5_pend_next", 32'(pending), 32'b001);
    check_eq("t5_frame_cnt", 32'(frame_cnt), 32'd7);

    // Reset asserted at T+2 of a full commit
    go_active();
    wr(OBJ_BARL, 32'h0009_0009, 1'b0);
    wr(OBJ_BARR, 32'h000A_000A, 1'b0);
    pixel_y = 10'd479;
    @(negedge clk);
    pixel_y = 10'd480;
    @(negedge clk);
    check_eq("t6_en1", 32'(bus.loc_en), 32'd1);
    check_eq("t6_wd1", bus.loc_wdata, 32'h0007_0008);
    @(negedge clk);
    check_eq("t6_en2", 32'(bus.loc_en), 32'd1);
    #1 rst = 1'b0;
    #1;
    s0 = strb_cnt;
    i0 = irq_cnt;
    check_eq("t6_rst_en", 32'(bus.loc_en), 32'd0);
    check_eq("t6_rst_pend", 32'(pending), 32'd0);
    check_eq("t6_rst_cnt", 32'(frame_cnt), 32'd0);
    check_eq("t6_rst_sel", 32'(bus.loc_sel), 32'd0);
    check_eq("t6_rst_ready", 32'(bus.req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("t6_no_strobe", 32'(strb_cnt - s0), 32'd0);
    check_eq("t6_no_irq", 32'(irq_cnt - i0), 32'd0);
    check_eq("t6_cnt_after", 32'(frame_cnt), 32'd0);
    check_eq("t6_ready_after", 32'(bus.req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/im_frame_sync_ctrl.md
Name: im_frame_sync_ctrl

Overview:
- Frame-synchronous update scheduler for the Pong image-memory location registers (ball, left bar, right bar).
- CPU-side location writes are captured into per-object shadow slots.
- At each vertical-blank entry, pending slots are committed to the image-memory register port in a fixed 3-cycle sequence, so the display never tears mid-frame.
- Also provides a frame counter and an end-of-commit frame interrupt pulse.

Parameters:
- H_ACTIVE, 640, visible pixels per line; x-field clamp limit.
- V_ACTIVE, 480, visible lines; vblank starts when pixel_y >= V_ACTIVE.
- FCNT_W, 16, frame counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- pixel_x  in  10  current scan x (unused except for debug, reserved)
- pixel_y  in  10  current scan y
- req_valid  in  1  CPU location write request
- req_obj  in  2  0=ball, 1=left bar, 2=right bar, 3=invalid
- req_data  in  32  [25:16]=y, [9:0]=x; other bits ignored
- req_ready  out  1  request accepted when valid&ready
- freeze  in  1  level; 1 suppresses commits (pause)
- ovr_clr  in  1  clears ovr flag
- loc_en  out  1  one-cycle write strobe to image-memory location register
- loc_sel  out  2  target register of loc_en
- loc_wdata  out  32  committed value {6'b0,y,6'b0,x}
- pending  out  3  per-object pending flags
- ovr  out  1  sticky: a pending slot was overwritten before commit
- frame_cnt  out  FCNT_W  frames seen, wraps
- frame_irq  out  1  one-cycle pulse at end of each frame-start handling

Behaviour:
- Reset (rst=0, async): all outputs 0; shadows 0; state IDLE. vblank_q resets to 1, so no spurious frame_start is generated if reset releases inside vblank.
- vblank = (pixel_y >= V_ACTIVE), registered into vblank_q. frame_start = vblank & ~vblank_q (rising edge only).
- Accept rules:
  - req_ready = (state==IDLE).
  - On accept with req_obj<3: x is clamped to min(x, H_ACTIVE-1) and y to min(y, V_ACTIVE-1). The value is written to shadow[req_obj] and pending[req_obj] is set.
  - If the object was already pending, the new value replaces the old one (last wins) and ovr is set.
  - req_obj==3 is accepted and dropped, with no state change.
- ovr: cleared by ovr_clr. If set and clear occur in the same cycle, set wins.
- frame_cnt increments on every frame_start in any state and wraps at 2^FCNT_W.
- FSM states: IDLE, COMMIT, DONE.
  - IDLE + frame_start: if freeze=0 and |pending, go to COMMIT with idx=0. Otherwise go to DONE.
  - COMMIT: one cycle per idx, 0..2, always 3 cycles.
    - If pending[idx]: loc_en=1, loc_sel=idx, loc_wdata=shadow[idx], and pending[idx] clears.
    - Otherwise loc_en=0.
    - After idx=2, go to DONE.
  - DONE: frame_irq=1 for one cycle, then IDLE.
  - frame_start while in COMMIT or DONE: counted but not commit-triggering (missed frame).
- Latency from frame_start at cycle T: state COMMIT at T+1, strobes in T+1..T+3, frame_irq at T+4, req_ready high again at T+5. With nothing pending or freeze=1, frame_irq occurs at T+1.
- A request accepted in the same cycle as frame_start is included in that commit.
- freeze: pending slots and shadows are retained and commit at the first unfrozen frame_start.
- loc_sel and loc_wdata hold their last driven values when loc_en=0. Only loc_en is meaningful to the consumer.
- Reset asserted mid-commit: immediate return to reset state; uncommitted updates are lost, and no partial strobe follows.

Decomposition:
- Package im_ctrl_pkg holds:
  - the FSM state enum;
  - OBJ_BALL, OBJ_BARL and OBJ_BARR constants;
  - the Y_LSB=16 and X_LSB=0 field positions;
  - a COORD_W=10 constant.
- One sub-module, im_vblank_det: compares pixel_y against V_ACTIVE, registers the result with reset-to-1, and emits the frame_start pulse.
- Shadow, pending and FSM logic stay in the top module.

Test Plan:
- Reset release with pixel_y=500 -> no frame_irq and frame_cnt=0. The first frame_irq follows the next 479->480 transition.
- Write ball=0x00640032 in the active region, then pixel_y 479->480 at T -> loc_en only at T+1 with loc_sel=0 and loc_wdata=0x00640032; frame_irq at T+4; pending=000 afterwards.
- Write barl twice (0x00100010, then 0x00200020) before vblank -> ovr=1; a single strobe at T+2 carries 0x00200020. Assert ovr_clr and a new overwrite in the same cycle -> ovr stays 1.
- Write barr y=900, x=1000 -> committed 0x01DF027F (clamped to 479/639).
- freeze=1 with ball pending across two vblank entries -> no loc_en, frame_irq at T+1 each frame, frame_cnt +2. After freeze=0, the next vblank commits.
- Issue req_valid during COMMIT -> req_ready=0 until T+5, and the request lands as pending for the next frame. Reset asserted at T+2 -> all outputs 0 immediately and no further strobes.
